store_write_buffer: RTL and testbench

Posted-store write buffer between the pipeline's memory stage and the data memory. Stores issued by the core (`memwrite`, `dataadr`, `writedata`) are queued and drained to data memory under a ready handshake. Loads are serviced by forwarding from the newest matching queued store. The memory stage stalls only when the buffer is full.

---
 rtl/mips_pkg.sv | 12 +
 rtl/wb_fwd_match.sv | 37 +++
 rtl/store_write_buffer.sv | 111 +++++++++++
 tb/tb_store_write_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the memory-stage store write buffer.
package mips_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ADDR_LSB = 2;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Store-to-load forwarding: picks the youngest occupied entry whose word address
// matches the load, searching backwards from the entry just before the write index.
module wb_fwd_match
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WAW   = 30,
    parameter int unsigned DW    = 32,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic                       ld_valid,
    input  logic [WAW-1:0]             ld_waddr,
    input  logic [DEPTH-1:0][WAW-1:0]  ent_waddr,
    input  logic [DEPTH-1:0][DW-1:0]   ent_data,
    input  logic [DEPTH-1:0]           ent_valid,
    input  logic [IW-1:0]              wr_idx,
    output logic                       hit,
    output logic [DW-1:0]              data
);

    logic [IW-1:0] idx;

    // k = 1 is the most recent push; the first match found wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            idx = IW'(wr_idx - IW'(k));
            if (!hit && ld_valid && ent_valid[idx] && (ent_waddr[idx] == ld_waddr)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store write buffer: queues core stores, drains them to data memory under
// a ready handshake, and forwards queued data to matching loads.
module store_write_buffer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     stall,
    output logic                     dm_we,
    output logic [AW-1:0]            dm_addr,
    output logic [DW-1:0]            dm_wdata,
    input  logic                     dm_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned PW  = IW + 1;
    localparam int unsigned WAW = AW - ADDR_LSB;

    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [DEPTH-1:0][AW-1:0]    addr_q;
    logic [DEPTH-1:0][DW-1:0]    data_q;

    logic                        full;
    logic                        push;
    logic                        pop;
    logic [IW-1:0]               wr_idx;
    logic [IW-1:0]               rd_idx;
    logic [IW-1:0]               off;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][WAW-1:0]   ent_waddr;
    logic                        unused_ld_lsb;

    assign wr_idx = wr_ptr[IW-1:0];
    assign rd_idx = rd_ptr[IW-1:0];

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign count  = PW'(wr_ptr - rd_ptr);
    assign empty  = (count == '0);
    assign full   = (count == PW'(DEPTH));

    assign push   = st_valid & ~full;
    assign stall  = st_valid & full;
    assign dm_we  = ~empty;
    assign pop    = dm_we & dm_ready;

    assign dm_addr  = empty ? '0 : addr_q[rd_idx];
    assign dm_wdata = empty ? '0 : data_q[rd_idx];

    // Byte-within-word bits play no part in forwarding.
    assign unused_ld_lsb = ^ld_addr[ADDR_LSB-1:0];

    // Slot i is occupied when its distance from the head is below the count.
    always_comb begin
        ent_valid = '0;
        ent_waddr = '0;
        off       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off          = IW'(IW'(i) - rd_idx);
            ent_valid[i] = ({1'b0, off} < count);
            ent_waddr[i] = addr_q[i][AW-1:ADDR_LSB];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (push) begin
                addr_q[wr_idx] <= st_addr;
                data_q[wr_idx] <= st_data;
                wr_ptr         <= PW'(wr_ptr + PW'(1));
            end
            if (pop) begin
                rd_ptr <= PW'(rd_ptr + PW'(1));
            end
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .WAW   (WAW),
        .DW    (DW)
    ) u_fwd (
        .ld_valid  (ld_valid),
        .ld_waddr  (ld_addr[AW-1:ADDR_LSB]),
        .ent_waddr (ent_waddr),
        .ent_data  (data_q),
        .ent_valid (ent_valid),
        .wr_idx    (wr_idx),
        .hit       (ld_hit),
        .data      (ld_data)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drain order, full/stall, forwarding, async reset.
module tb_store_write_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        stall;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [2:0]  count;
    logic        empty;

    int total;
    int bad;

    store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .stall    (stall),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ready (dm_ready),
        .count    (count),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs on the falling edge; outputs settle before the next rise.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la, input logic rdy);
        @(negedge clk);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
        dm_ready = rdy;
        #1;
    endtask

    task automatic test_reset;
        #3;
        total++; if (count !== 3'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (dm_we !== 1'b0)     begin bad++; $display("FAIL reset_dm_we got=%b exp=0", dm_we); end
        total++; if (dm_addr !== 32'h0)  begin bad++; $display("FAIL reset_dm_addr got=%h exp=0", dm_addr); end
        total++; if (dm_wdata !== 32'h0) begin bad++; $display("FAIL reset_dm_wdata got=%h exp=0", dm_wdata); end
        total++; if (stall !== 1'b0)     begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (ld_hit !== 1'b0)    begin bad++; $display("FAIL reset_ld_hit got=%b exp=0", ld_hit); end
        total++; if (ld_data !== 32'h0)  begin bad++; $display("FAIL reset_ld_data got=%h exp=0", ld_data); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
            total++; if (empty !== 1'b1 || dm_we !== 1'b0 || stall !== 1'b0 || count !== 3'd0)
                begin bad++; $display("FAIL idle_state got=e%b w%b s%b c%0d exp=e1 w0 s0 c0", empty, dm_we, stall, count); end
        end
    endtask

    task automatic test_single_store;
        step(1'b1, 32'h80, 32'h0, 1'b0, 32'h0, 1'b1);
        total++; if (stall !== 1'b0 || empty !== 1'b1 || dm_we !== 1'b0)
            begin bad++; $display("FAIL single_pre got=s%b e%b w%b exp=s0 e1 w0", stall, empty, dm_we); end
        step(1'b1, 32'h84, 32'h7, 1'b0, 32'h0, 1'b1);
        total++; if (dm_we !== 1'b1 || dm_addr !== 32'h80 || dm_wdata !== 32'h0 || count !== 3'd1)
            begin bad++; $display("FAIL single_first got=w%b a%h d%h c%0d exp=w1 a80 d0 c1", dm_we, dm_addr, dm_wdata, count); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        total++; if (dm_we !== 1'b1 || dm_addr !== 32'h84 || dm_wdata !== 32'h7 || count !== 3'd1)
            begin bad++; $display("FAIL single_second got=w%b a%h d%h c%0d exp=w1 a84 d7 c1", dm_we, dm_addr, dm_wdata, count); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        total++; if (empty !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h0)
            begin bad++; $display("FAIL single_after got=e%b w%b a%h exp=e1 w0 a0", empty, dm_we, dm_addr); end
    endtask

    task automatic test_fill_wrap;
        logic [31:0] exp_a [5];
        logic [31:0] exp_d [5];
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h20, 32'hA4, 1'b0, 32'h0, 1'b0);
        total++; if (stall !== 1'b1 || count !== 3'd4)
            begin bad++; $display("FAIL fill_full got=s%b c%0d exp=s1 c4", stall, count); end
        // Full: stall holds even with a pop this cycle.
        step(1'b1, 32'h20, 32'hA4, 1'b0, 32'h0, 1'b1);
        total++; if (stall !== 1'b1 || dm_addr !== 32'h10 || dm_wdata !== 32'hA0)
            begin bad++; $display("FAIL fill_pop_stall got=s%b a%h d%h exp=s1 a10 dA0", stall, dm_addr, dm_wdata); end
        step(1'b1, 32'h20, 32'hA4, 1'b0, 32'h0, 1'b1);
        total++; if (stall !== 1'b0 || count !== 3'd3 || dm_addr !== 32'h14)
            begin bad++; $display("FAIL fill_accept got=s%b c%0d a%h exp=s0 c3 a14", stall, count, dm_addr); end
        exp_a = '{32'h14, 32'h18, 32'h1C, 32'h20, 32'h0};
        exp_d = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0};
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
            total++; if (dm_addr !== exp_a[i] || dm_wdata !== exp_d[i])
                begin bad++; $display("FAIL fill_drain%0d got=a%h d%h exp=a%h d%h", i, dm_addr, dm_wdata, exp_a[i], exp_d[i]); end
        end
        total++; if (empty !== 1'b1)
            begin bad++; $display("FAIL fill_empty got=%b exp=1", empty); end
    endtask

    task automatic test_forwarding;
        step(1'b1, 32'h84, 32'h7, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h84, 32'h9, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h84, 1'b0);
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'h9 || count !== 3'd2)
            begin bad++; $display("FAIL fwd_84 got=h%b d%h c%0d exp=h1 d9 c2", ld_hit, ld_data, count); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h86, 1'b0);
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'h9)
            begin bad++; $display("FAIL fwd_86 got=h%b d%h exp=h1 d9", ld_hit, ld_data); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h88, 1'b0);
        total++; if (ld_hit !== 1'b0 || ld_data !== 32'h0)
            begin bad++; $display("FAIL fwd_88 got=h%b d%h exp=h0 d0", ld_hit, ld_data); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h84, 1'b0);
        total++; if (ld_hit !== 1'b0 || ld_data !== 32'h0)
            begin bad++; $display("FAIL fwd_noload got=h%b d%h exp=h0 d0", ld_hit, ld_data); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h84, 1'b1);
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'h9 || dm_wdata !== 32'h7)
            begin bad++; $display("FAIL fwd_pop_old got=h%b d%h w%h exp=h1 d9 w7", ld_hit, ld_data, dm_wdata); end
        // Sole remaining entry is being popped yet still forwards.
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h84, 1'b1);
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'h9 || dm_wdata !== 32'h9)
            begin bad++; $display("FAIL fwd_pop_head got=h%b d%h w%h exp=h1 d9 w9", ld_hit, ld_data, dm_wdata); end
        step(1'b1, 32'h90, 32'h55, 1'b1, 32'h90, 1'b0);
        total++; if (ld_hit !== 1'b0 || stall !== 1'b0 || empty !== 1'b1)
            begin bad++; $display("FAIL fwd_same_cycle got=h%b s%b e%b exp=h0 s0 e1", ld_hit, stall, empty); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h90, 1'b0);
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'h55)
            begin bad++; $display("FAIL fwd_next_cycle got=h%b d%h exp=h1 d55", ld_hit, ld_data); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        total++; if (empty !== 1'b1)
            begin bad++; $display("FAIL fwd_drained got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 32'h100, 32'h1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h104, 32'h2, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h108, 32'h3, 1'b0, 32'h0, 1'b1);
        total++; if (count !== 3'd2 || dm_addr !== 32'h100 || stall !== 1'b0)
            begin bad++; $display("FAIL b2b_pre got=c%0d a%h s%b exp=c2 a100 s0", count, dm_addr, stall); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h108, 1'b0);
        total++; if (count !== 3'd2 || dm_addr !== 32'h104 || dm_wdata !== 32'h2)
            begin bad++; $display("FAIL b2b_post got=c%0d a%h d%h exp=c2 a104 d2", count, dm_addr, dm_wdata); end
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'h3)
            begin bad++; $display("FAIL b2b_tail got=h%b d%h exp=h1 d3", ld_hit, ld_data); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0);
        total++; if (ld_hit !== 1'b0)
            begin bad++; $display("FAIL b2b_popped got=h%b exp=h0", ld_hit); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        total++; if (empty !== 1'b1)
            begin bad++; $display("FAIL b2b_drained got=%b exp=1", empty); end
    endtask

    task automatic test_async_reset;
        step(1'b1, 32'h200, 32'hB0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h204, 32'hB1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h208, 32'hB2, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h204, 1'b0);
        total++; if (count !== 3'd3 || ld_hit !== 1'b1 || ld_data !== 32'hB1)
            begin bad++; $display("FAIL areset_pre got=c%0d h%b d%h exp=c3 h1 dB1", count, ld_hit, ld_data); end
        #2 reset = 1'b1;
        #1;
        total++; if (count !== 3'd0 || empty !== 1'b1 || dm_we !== 1'b0)
            begin bad++; $display("FAIL areset_now got=c%0d e%b w%b exp=c0 e1 w0", count, empty, dm_we); end
        total++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0 || ld_hit !== 1'b0 || ld_data !== 32'h0 || stall !== 1'b0)
            begin bad++; $display("FAIL areset_out got=a%h d%h h%b ld%h s%b exp=all zero", dm_addr, dm_wdata, ld_hit, ld_data, stall); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 32'h208, 1'b1);
            total++; if (dm_we !== 1'b0 || empty !== 1'b1 || ld_hit !== 1'b0)
                begin bad++; $display("FAIL areset_after%0d got=w%b e%b h%b exp=w0 e1 h0", i, dm_we, empty, ld_hit); end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        dm_ready = 1'b0;
        test_reset();
        test_single_store();
        test_fill_wrap();
        test_forwarding();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
